// File: rtl/slave_port.sv
// Slave endpoint of the serial bus: shifts in an LSB-first address (plus write data),
// presents it in parallel, and serialises a byte from local storage for reads.
module slave_port #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              read_enable,
    input  logic              write_enable,
    input  logic              m_ready,
    input  logic              m_valid,
    output logic              s_valid,
    output logic              s_ready,
    input  logic              rx_address,
    input  logic              rx_data,
    output logic              tx_data,
    input  logic [DATA_W-1:0] data_input,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    // state     | meaning
    // IDLE      | ready for a new transaction (s_ready=1)
    // RX        | shifting in address bits 1..ADDR_W-1 (and write data)
    // READ_WAIT | address received for a read, waiting for m_ready
    // TX        | shifting the latched read byte out on tx_data
    localparam int CNT_W = $clog2(ADDR_W + 1);

    typedef enum logic [1:0] {IDLE, RX, READ_WAIT, TX} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic              is_write;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic [DATA_W-1:0] tx_sr;
    logic              start;
    logic              rx_done;
    logic              tx_done;

    assign start   = (state == IDLE) && m_valid && (write_enable || read_enable);
    assign rx_done = (state == RX) && (bit_cnt == CNT_W'(ADDR_W));
    assign tx_done = (state == TX) && (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = RX;
            RX:        if (rx_done) state_nxt = is_write ? IDLE : READ_WAIT;
            READ_WAIT: if (m_ready) state_nxt = TX;
            TX:        if (tx_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Shift registers fill from the top so that after the full count the first
    // (LSB) bit received has landed in bit 0.
    always_ff @(posedge clk) begin
        if (rstn) begin
            bit_cnt  <= '0;
            is_write <= 1'b0;
            addr_sr  <= '0;
            data_sr  <= '0;
            tx_sr    <= '0;
            address  <= '0;
            data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_write <= write_enable;
                        addr_sr  <= {rx_address, addr_sr[ADDR_W-1:1]};
                        if (write_enable) begin
                            data_sr <= {rx_data, data_sr[DATA_W-1:1]};
                        end
                        bit_cnt <= CNT_W'(1);
                    end
                end
                RX: begin
                    if (!rx_done) begin
                        addr_sr <= {rx_address, addr_sr[ADDR_W-1:1]};
                        if (is_write && (bit_cnt < CNT_W'(DATA_W))) begin
                            data_sr <= {rx_data, data_sr[DATA_W-1:1]};
                        end
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        address <= addr_sr;
                        if (is_write) begin
                            data <= data_sr;
                        end
                        bit_cnt <= '0;
                    end
                end
                READ_WAIT: begin
                    if (m_ready) begin
                        tx_sr   <= data_input;
                        bit_cnt <= '0;
                    end
                end
                TX: begin
                    tx_sr   <= {1'b0, tx_sr[DATA_W-1:1]};
                    bit_cnt <= tx_done ? '0 : bit_cnt + 1'b1;
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    assign s_ready = (state == IDLE);
    assign s_valid = (state == TX);
    assign tx_data = s_valid & tx_sr[0];

endmodule

// File: tb/tb_slave_port.sv
// Randomised bench for slave_port: a value-level model tracks the expected
// address/data outputs and the serial read bytes for every transaction.
module tb_slave_port;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              read_enable;
    logic              write_enable;
    logic              m_ready;
    logic              m_valid;
    logic              s_valid;
    logic              s_ready;
    logic              rx_address;
    logic              rx_data;
    logic              tx_data;
    logic [DATA_W-1:0] data_input;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;

    int n_cmp = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    slave_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .m_ready      (m_ready),
        .m_valid      (m_valid),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .rx_address   (rx_address),
        .rx_data      (rx_data),
        .tx_data      (tx_data),
        .data_input   (data_input),
        .address      (address),
        .data         (data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_addr"}, 32'(address), 32'(exp_addr));
        chk({tag, "_data"}, 32'(data), 32'(exp_data));
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_s_valid"}, 32'(s_valid), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        if (s_ready !== 1'b1) chk("ready_timeout", 32'(s_ready), 32'd1);
    endtask

    // Full transaction driven from a negedge with the slave idle.
    // wr/both select the op; stall = cycles m_ready is held low before the pulse.
    task automatic run_txn(input bit wr, input bit both, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rd,
                           input int stall, input bit rand_ctl);
        bit is_wr;
        is_wr = wr || both;
        m_valid      = 1'b1;
        write_enable = is_wr;
        read_enable  = both || !wr;
        for (int k = 0; k < ADDR_W; k++) begin
            rx_address = a[k];
            rx_data    = (is_wr && k < DATA_W) ? d[k] : 1'($urandom);
            if (k > 0 && rand_ctl) begin
                m_valid      = 1'($urandom);
                write_enable = 1'($urandom);
                read_enable  = 1'($urandom);
            end
            if (k == ADDR_W - 1) m_valid = 1'b0;
            cyc();
            if (k == 3) chk("rx_busy", 32'(s_ready), 32'd0);
        end
        m_valid      = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        rx_address   = 1'($urandom);
        rx_data      = 1'($urandom);
        cyc();
        exp_addr = a;
        if (is_wr) exp_data = d;
        chk("end_addr", 32'(address), 32'(exp_addr));
        chk("end_data", 32'(data), 32'(exp_data));
        chk("end_s_ready", 32'(s_ready), 32'(is_wr));
        chk("end_s_valid", 32'(s_valid), 32'd0);
        if (is_wr) begin
            cyc();
            chk("wr_no_tx", 32'(s_valid), 32'd0);
        end else begin
            for (int i = 0; i < stall; i++) begin
                data_input = DATA_W'($urandom);
                cyc();
                if (s_valid !== 1'b0 || s_ready !== 1'b0 || i == stall - 1) begin
                    chk("stall_s_valid", 32'(s_valid), 32'd0);
                    chk("stall_s_ready", 32'(s_ready), 32'd0);
                end
            end
            data_input = rd;
            m_ready    = 1'b1;
            cyc();
            m_ready    = 1'b0;
            for (int i = 0; i < DATA_W; i++) begin
                data_input = DATA_W'($urandom);
                chk($sformatf("tx_bit%0d", i), 32'(tx_data), 32'(rd[i]));
                chk($sformatf("tx_valid%0d", i), 32'(s_valid), 32'd1);
                cyc();
            end
            chk_idle_outputs("post_tx");
        end
    endtask

    initial begin
        rstn = 1'b1; read_enable = 1'b0; write_enable = 1'b0; m_ready = 1'b0;
        m_valid = 1'b0; rx_address = 1'b0; rx_data = 1'b0; data_input = '0;
        exp_addr = '0;
        exp_data = '0;
        @(negedge clk);
        repeat (3) cyc();
        rstn = 1'b0;
        chk_idle_outputs("reset");

        // m_valid without any enable must not start a transaction
        m_valid = 1'b1; rx_address = 1'b1; rx_data = 1'b1;
        cyc();
        m_valid = 1'b0;
        cyc();
        chk("no_enable_ready", 32'(s_ready), 32'd1);

        run_txn(1'b1, 1'b0, 12'h9B5, 8'h79, 8'h00, 0, 1'b0);
        chk("dir_wr_addr", 32'(address), 32'h9B5);
        chk("dir_wr_data", 32'(data), 32'h79);
        wait_ready();
        run_txn(1'b0, 1'b0, 12'h9B5, 8'h00, 8'hCC, 2, 1'b0);
        chk("dir_rd_data_kept", 32'(data), 32'h79);
        wait_ready();
        run_txn(1'b0, 1'b1, 12'h3C6, 8'hA5, 8'h5A, 0, 1'b0);
        wait_ready();
        run_txn(1'b0, 1'b0, 12'h0F1, 8'h00, 8'h96, 50, 1'b1);
        wait_ready();

        // reset in the middle of RX
        m_valid = 1'b1; write_enable = 1'b1; read_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rx_address = 1'($urandom);
            rx_data    = 1'($urandom);
            cyc();
        end
        m_valid = 1'b0; write_enable = 1'b0;
        rstn = 1'b1;
        cyc();
        rstn = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        chk_idle_outputs("mid_rx_reset");
        run_txn(1'b1, 1'b0, 12'hE27, 8'h3B, 8'h00, 0, 1'b1);
        wait_ready();

        for (int t = 0; t < 24; t++) begin
            run_txn(1'($urandom), 1'($urandom_range(0, 3) == 0), ADDR_W'($urandom),
                    DATA_W'($urandom), DATA_W'($urandom), $urandom_range(0, 6), 1'b1);
            wait_ready();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Slave-side endpoint of the serial bus.
- Receives a serial address (and, for writes, serial write data) from the master, then presents them as parallel outputs.
- For reads, it returns a parallel byte from local storage to the master serially.
- Sits between the serial bus wires and a slave's local memory/register block.

Parameters:
ADDR_W, 12, address width / number of serial address bits
DATA_W, 8, data width / number of serial data bits

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  reset; synchronous, active-high (asserted = 1, despite the name)
read_enable  input  1  master requests read; sampled only at transaction start
write_enable  input  1  master requests write; sampled only at transaction start
m_ready  input  1  master ready to receive read data; single-cycle pulse accepted
m_valid  input  1  master transaction valid; sampled only at transaction start
s_valid  output  1  high while tx_data carries a valid read bit
s_ready  output  1  high when slave is idle and can accept a transaction
rx_address  input  1  serial address bit from master, LSB first
rx_data  input  1  serial write-data bit from master, LSB first
tx_data  output  1  serial read-data bit to master, LSB first
data_input  input  DATA_W  parallel read data from local storage
address  output  ADDR_W  last received address
data  output  DATA_W  last received write data

Behaviour:
- States: IDLE, RX (receive), READ_WAIT, TX.
- Reset (rstn=1 at a clock edge): state=IDLE, address=0, data=0, tx_data=0, s_valid=0, s_ready=1, counters and shift registers cleared.
- Reset has priority over everything and aborts any transaction in progress.
- IDLE, s_ready=1:
  - On an edge with m_valid=1 and (write_enable or read_enable), start a transaction.
  - That same edge samples rx_address into address bit 0 and rx_data into data bit 0.
  - Latch op: write if write_enable=1, else read. Write wins if both are set.
  - Go to RX; s_ready=0.
- RX:
  - Each subsequent edge samples the next rx_address bit; ADDR_W bits total, bit k on the k-th start-relative edge (k=0..11).
  - For writes, rx_data is sampled on the same edges for the first DATA_W bits (k=0..7); later rx_data values are ignored.
  - For reads, rx_data is ignored.
  - m_valid, write_enable and read_enable are ignored after the start edge; deassertion does not abort.
- End of RX: the edge after the edge sampling bit 11.
  - Write: address and data outputs update together; go to IDLE, s_ready=1.
  - Read: address updates, data is unchanged; go to READ_WAIT.
- READ_WAIT:
  - s_ready=0, s_valid=0.
  - Wait indefinitely for m_ready=1.
  - On that edge, latch data_input into the tx shift register and go to TX.
- TX:
  - For DATA_W consecutive cycles, tx_data = latched bit i (i=0..7, LSB first) and s_valid=1.
  - Changes in data_input after the latch edge do not affect the transmission.
  - After the 8th bit, tx_data=0, s_valid=0, state=IDLE, s_ready=1.
- Outputs are registered.
- tx_data=0 whenever s_valid=0.
- address and data hold their values between transactions.
- Back-to-back: a new start is accepted on the first edge at which the state is IDLE.

Test Plan:
- Reset: hold rstn=1 for 3 cycles -> address=0x000, data=0x00, s_ready=1, s_valid=0, tx_data=0.
- Write: start with m_valid=1, write_enable=1. rx_address bits (LSB first) 1,0,1,0,1,1,0,1,1,0,0,1; rx_data bits 1,0,0,1,1,1,1,0. Drop m_valid during bit 11 -> after bit 11, address=0x9B5, data=0x79, s_ready back to 1.
- Read: same address with read_enable=1; then data_input=0xCC and one-cycle m_ready pulse -> address=0x9B5, data unchanged. tx_data over the next 8 cycles = 0,0,1,1,0,0,1,1 with s_valid=1, then s_valid=0, s_ready=1.
- Both enables set at start -> treated as write; data updates and no tx activity occurs.
- Reset mid-RX (after 5 bits) -> IDLE; address and data forced to 0; a subsequent full write completes correctly.
- READ_WAIT stall: m_ready held low for 50 cycles -> s_valid stays 0 and s_ready stays 0; transmission starts only after m_ready.
